// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, captures {pc, instr} from the
// combinational instruction memory into a small FIFO, and hands words to decode.
module fetch_queue #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          DEPTH       = 4,
   parameter int          XLEN        = 32,
   parameter int          INSTR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fetch_en,
   input  logic                   redirect_valid,
   input  logic [XLEN-1:0]        redirect_pc,
   output logic [XLEN-1:0]        imem_pc,
   input  logic [INSTR_WIDTH-1:0] imem_instr,
   output logic                   out_valid,
   output logic [INSTR_WIDTH-1:0] out_instr,
   output logic [XLEN-1:0]        out_pc,
   input  logic                   out_ready
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   logic [XLEN-1:0]        fetch_pc;
   logic [XLEN-1:0]        pc_mem    [DEPTH];
   logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
   logic [PW-1:0]          rd_ptr;
   logic [PW-1:0]          wr_ptr;
   logic [PW:0]            count;
   logic                   pop;
   logic                   push;

   // A full FIFO may still accept a word when the head leaves in the same cycle.
   assign pop  = out_valid & out_ready & ~redirect_valid;
   assign push = fetch_en & ~redirect_valid & ((count < FULL_COUNT) | pop);

   assign out_valid = (count != '0);
   assign out_instr = instr_mem[rd_ptr];
   assign out_pc    = pc_mem[rd_ptr];
   assign imem_pc   = fetch_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            fetch_pc <= fetch_pc + XLEN'(4);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   // Storage carries no reset; entries are only observed while counted valid.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         pc_mem[wr_ptr]    <= fetch_pc;
         instr_mem[wr_ptr] <= imem_instr;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; instruction memory returns word index (pc >> 2).
module tb_fetch_queue;

   logic        clk;
   logic        rst;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;

   int compared;
   int mismatched;

   fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_pc        (imem_pc),
      .imem_instr     (imem_instr),
      .out_valid      (out_valid),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_ready      (out_ready)
   );

   assign imem_instr = imem_pc >> 2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      compared       = 0;
      mismatched     = 0;
      rst            = 1'b1;
      fetch_en       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;

      // Reset state
      tick();
      tick();
      check_output("reset_valid", 32'(out_valid), 32'd0);
      check_output("reset_imem_pc", imem_pc, 32'h0);

      // Streaming: one instruction per cycle after a one-cycle fill
      rst       = 1'b0;
      fetch_en  = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check_output($sformatf("stream_valid_%0d", k), 32'(out_valid), 32'd1);
         check_output($sformatf("stream_pc_%0d", k), out_pc, 32'(4 * k));
         check_output($sformatf("stream_instr_%0d", k), out_instr, 32'(k));
      end
      check_output("stream_imem_pc", imem_pc, 32'h18);

      // Back-pressure from reset: fill to four entries and stall fetch
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      fetch_en  = 1'b1;
      out_ready = 1'b0;
      tick();
      tick();
      check_output("stall_head_early", out_pc, 32'h0);
      for (int k = 0; k < 8; k++) tick();
      check_output("stall_imem_pc", imem_pc, 32'h10);
      check_output("stall_valid", 32'(out_valid), 32'd1);
      check_output("stall_head_pc", out_pc, 32'h0);
      check_output("stall_head_instr", out_instr, 32'h0);

      // Drain with fetch disabled: 0x4, 0x8, 0xC, then empty
      out_ready = 1'b1;
      fetch_en  = 1'b0;
      tick();
      check_output("drain_pc_1", out_pc, 32'h4);
      check_output("drain_hold_imem", imem_pc, 32'h10);
      tick();
      check_output("drain_pc_2", out_pc, 32'h8);
      tick();
      check_output("drain_pc_3", out_pc, 32'hC);
      check_output("drain_instr_3", out_instr, 32'h3);
      tick();
      check_output("drain_empty", 32'(out_valid), 32'd0);

      // Refill, then simultaneous pop and push on a full FIFO
      fetch_en  = 1'b1;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check_output("refill_imem_pc", imem_pc, 32'h20);
      check_output("refill_head", out_pc, 32'h10);
      out_ready = 1'b1;
      tick();
      check_output("full_pp_pc_1", out_pc, 32'h14);
      check_output("full_pp_imem_1", imem_pc, 32'h24);
      tick();
      check_output("full_pp_pc_2", out_pc, 32'h18);
      check_output("full_pp_imem_2", imem_pc, 32'h28);
      out_ready = 1'b0;
      tick();
      check_output("full_still_full", imem_pc, 32'h28);

      // Drop to three entries, then redirect to an unaligned target
      out_ready = 1'b1;
      fetch_en  = 1'b0;
      tick();
      check_output("pre_redirect_head", out_pc, 32'h1C);
      fetch_en       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      check_output("redir_valid_low", 32'(out_valid), 32'd0);
      check_output("redir_imem_pc", imem_pc, 32'h100);
      tick();
      check_output("redir_valid_high", 32'(out_valid), 32'd1);
      check_output("redir_first_pc", out_pc, 32'h100);
      check_output("redir_first_instr", out_instr, 32'h40);
      tick();
      check_output("redir_second_pc", out_pc, 32'h104);

      // Redirect to the top of the address space and wrap
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      check_output("wrap_valid_low", 32'(out_valid), 32'd0);
      tick();
      check_output("wrap_pc_top", out_pc, 32'hFFFF_FFFC);
      check_output("wrap_instr_top", out_instr, 32'h3FFF_FFFF);
      check_output("wrap_imem_pc", imem_pc, 32'h0);
      tick();
      check_output("wrap_pc_zero", out_pc, 32'h0);

      // Fill, then reset together with a redirect: reset wins
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check_output("prerst_imem_pc", imem_pc, 32'h10);
      rst            = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      out_ready      = 1'b1;
      tick();
      check_output("rst_redir_valid", 32'(out_valid), 32'd0);
      check_output("rst_redir_imem_pc", imem_pc, 32'h0);
      rst            = 1'b0;
      redirect_valid = 1'b0;
      fetch_en       = 1'b0;
      tick();
      check_output("rst_hold_imem_pc", imem_pc, 32'h0);
      check_output("rst_hold_valid", 32'(out_valid), 32'd0);
      fetch_en = 1'b1;
      tick();
      check_output("rst_first_pc", out_pc, 32'h0);
      check_output("rst_first_valid", 32'(out_valid), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
